// File: rtl/beamformer_pkg.sv
// rtl/beamformer_pkg.sv - shared sizes, FSM states and sample helper for the beam sequencer
package beamformer_pkg;

  localparam int NUMBER_OF_BITS = 8;
  localparam int BUFFER_SIZE    = 16;
  localparam int NUM_CHANNELS   = 2;
  localparam int FRAME_CYCLES   = 32;
  localparam int IDX_W          = $clog2(BUFFER_SIZE);
  localparam int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BEAM_W         = NUMBER_OF_BITS + CH_W;
  localparam int CNT_W          = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_OUT
  } state_e;

  function automatic logic signed [BEAM_W-1:0] sext_sample(input logic [NUMBER_OF_BITS-1:0] s);
    return $signed({{CH_W{s[NUMBER_OF_BITS-1]}}, s});
  endfunction

endpackage

// File: rtl/beam_sequencer_if.sv
// rtl/beam_sequencer_if.sv - delay config, channel buffer read and beam output signals
interface beam_sequencer_if;
  import beamformer_pkg::*;

  logic [CH_W-1:0]           cfg_sel;
  logic                      cfg_bit;
  logic                      cfg_shift;
  logic                      cfg_commit;
  logic                      cfg_pending;
  logic [CH_W-1:0]           rd_ch;
  logic [IDX_W-1:0]          rd_index;
  logic [NUMBER_OF_BITS-1:0] rd_data;
  logic [BEAM_W-1:0]         beam_out;
  logic                      beam_valid;

  modport master (
    input  cfg_sel, cfg_bit, cfg_shift, cfg_commit, rd_data,
    output cfg_pending, rd_ch, rd_index, beam_out, beam_valid
  );

  modport slave (
    output cfg_sel, cfg_bit, cfg_shift, cfg_commit, rd_data,
    input  cfg_pending, rd_ch, rd_index, beam_out, beam_valid
  );

endinterface

// File: rtl/beam_delay_regfile.sv
// rtl/beam_delay_regfile.sv - serially loaded shadow delays copied to active delays on frame strobe
module beam_delay_regfile
  import beamformer_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  frame_strobe,
  input  logic [CH_W-1:0]                       cfg_sel,
  input  logic                                  cfg_bit,
  input  logic                                  cfg_shift,
  input  logic                                  cfg_commit,
  output logic                                  cfg_pending,
  output logic [NUM_CHANNELS-1:0][IDX_W-1:0]    active
);

  logic [NUM_CHANNELS-1:0][IDX_W-1:0] shadow_q, shadow_d;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] active_q, active_d;
  logic                               pending_q, pending_d;
  logic                               sel_ok;

  assign sel_ok = ({1'b0, cfg_sel} < (CH_W+1)'(NUM_CHANNELS));

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q | cfg_commit;
    if (cfg_shift && sel_ok) begin
      shadow_d[cfg_sel] = {shadow_q[cfg_sel][IDX_W-2:0], cfg_bit};
    end
    // Copy reads shadow_q, so a shift landing in the same cycle is not taken.
    if (frame_strobe && (pending_q || cfg_commit)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active      = active_q;
  assign cfg_pending = pending_q;

endmodule

// File: rtl/beam_sequencer.sv
// rtl/beam_sequencer.sv - frame counter, word select, and per-frame delay-and-sum beam sequencing
module beam_sequencer
  import beamformer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic             ws_out,
  output logic             frame_strobe,
  output logic             busy,
  beam_sequencer_if.master bus
);

  if ((FRAME_CYCLES % 2) != 0 || FRAME_CYCLES < 2*NUM_CHANNELS+2) begin : g_bad_frame
    $error("FRAME_CYCLES must be even and >= 2*NUM_CHANNELS+2");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES-1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAME_CYCLES/2);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS-1);

  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               ws_q, ws_d;
  state_e                             state_q, state_d;
  logic [CH_W-1:0]                    k_q, k_d;
  logic signed [BEAM_W-1:0]           acc_q, acc_d, acc_sum;
  logic [BEAM_W-1:0]                  beam_out_q, beam_out_d;
  logic                               beam_valid_q, beam_valid_d;
  logic [CH_W-1:0]                    rd_ch_q, rd_ch_d;
  logic [IDX_W-1:0]                   rd_index_q, rd_index_d;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] active;

  beam_delay_regfile u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_strobe (frame_strobe),
    .cfg_sel      (bus.cfg_sel),
    .cfg_bit      (bus.cfg_bit),
    .cfg_shift    (bus.cfg_shift),
    .cfg_commit   (bus.cfg_commit),
    .cfg_pending  (bus.cfg_pending),
    .active       (active)
  );

  assign frame_strobe = (cnt_q == CNT_LAST);
  assign acc_sum      = acc_q + sext_sample(bus.rd_data);

  always_comb begin
    cnt_d        = frame_strobe ? '0 : cnt_q + 1'b1;
    ws_d         = (cnt_d >= CNT_HALF);
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    beam_out_d   = beam_out_q;
    beam_valid_d = 1'b0;
    rd_ch_d      = rd_ch_q;
    rd_index_d   = rd_index_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_strobe && ena) begin
          state_d = ST_ADDR;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        rd_ch_d    = k_q;
        rd_index_d = active[k_q];
        if (k_q == CH_LAST) begin
          beam_out_d   = acc_sum;
          beam_valid_d = 1'b1;
          state_d      = ST_OUT;
        end else begin
          acc_d   = acc_sum;
          k_d     = k_q + 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      ws_q         <= 1'b0;
      state_q      <= ST_IDLE;
      k_q          <= '0;
      acc_q        <= '0;
      beam_out_q   <= '0;
      beam_valid_q <= 1'b0;
      rd_ch_q      <= '0;
      rd_index_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      ws_q         <= ws_d;
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      beam_out_q   <= beam_out_d;
      beam_valid_q <= beam_valid_d;
      rd_ch_q      <= rd_ch_d;
      rd_index_q   <= rd_index_d;
    end
  end

  // Address is live from k during a sequence; the last one used is held in IDLE.
  assign bus.rd_ch      = (state_q == ST_IDLE) ? rd_ch_q : k_q;
  assign bus.rd_index   = (state_q == ST_IDLE) ? rd_index_q : active[k_q];
  assign bus.beam_out   = beam_out_q;
  assign bus.beam_valid = beam_valid_q;
  assign ws_out         = ws_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_beam_sequencer.sv
// tb/tb_beam_sequencer.sv - directed self-checking bench for beam_sequencer
module tb_beam_sequencer;

  logic clk;
  logic rst_n;
  logic ena;
  logic ws_out;
  logic frame_strobe;
  logic busy;
  logic [7:0] buf0 [16];
  logic [7:0] buf1 [16];
  int tests_run;
  int tests_failed;

  beam_sequencer_if ifc ();

  beam_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ws_out       (ws_out),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .bus          (ifc)
  );

  assign ifc.rd_data = (ifc.rd_ch == 1'b0) ? buf0[ifc.rd_index] : buf1[ifc.rd_index];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_strobe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_strobe: no frame_strobe within 40 cycles");
    end
  endtask

  task automatic run_frame(output int lat, output int nvalid, output logic [8:0] beam);
    bit ok;
    lat = -1;
    nvalid = 0;
    beam = 9'h000;
    wait_strobe(ok);
    if (!ok) return;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ifc.beam_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = i;
          beam = ifc.beam_out;
        end
      end
    end
  endtask

  task automatic fill_bufs(input logic [7:0] b0, input logic [7:0] b1, input bit ramp1);
    for (int i = 0; i < 16; i++) begin
      buf0[i] = b0 + (ramp1 ? 8'(i) : 8'h00);
      buf1[i] = ramp1 ? 8'(i) : b1;
    end
  endtask

  task automatic shift_bits(input logic sel, input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      ifc.cfg_sel   = sel;
      ifc.cfg_bit   = bits[i];
      ifc.cfg_shift = 1'b1;
      @(negedge clk);
    end
    ifc.cfg_shift = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ws_out, frame_strobe, busy, ifc.beam_valid, ifc.cfg_pending} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 00000", {ws_out, frame_strobe, busy, ifc.beam_valid, ifc.cfg_pending});
    end
    tests_run++;
    if ({ifc.rd_ch, ifc.rd_index, ifc.beam_out} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got %h want 0", {ifc.rd_ch, ifc.rd_index, ifc.beam_out});
    end
    rst_n = 1'b1;
    wait_strobe(ok);
    if (!ok) return;
    tests_run++;
    if (ws_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL ws_at_strobe: got %b want 1", ws_out);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      tests_run++;
      if (ws_out !== (i >= 16)) begin
        tests_failed++;
        $display("FAIL ws_phase[%0d]: got %b want %b", i, ws_out, (i >= 16));
      end
      tests_run++;
      if (frame_strobe !== (i == 31)) begin
        tests_failed++;
        $display("FAIL strobe_phase[%0d]: got %b want %b", i, frame_strobe, (i == 31));
      end
      tests_run++;
      if ({ifc.beam_valid, busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL idle_when_disabled[%0d]: got %b want 00", i, {ifc.beam_valid, busy});
      end
    end
  endtask

  task automatic test_basic_sum;
    int lat, nvalid;
    logic [8:0] beam;
    fill_bufs(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    ena = 1'b1;
    run_frame(lat, nvalid, beam);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 5", lat);
    end
    tests_run++;
    if (nvalid !== 1) begin
      tests_failed++;
      $display("FAIL basic_valid_pulses: got %0d want 1", nvalid);
    end
    tests_run++;
    if (beam !== 9'h030) begin
      tests_failed++;
      $display("FAIL basic_beam: got %h want 030", beam);
    end
  endtask

  task automatic test_signed_sum;
    int lat, nvalid;
    logic [8:0] beam;
    fill_bufs(8'h80, 8'h80, 1'b0);
    run_frame(lat, nvalid, beam);
    tests_run++;
    if (beam !== 9'h100) begin
      tests_failed++;
      $display("FAIL signed_neg: got %h want 100", beam);
    end
    fill_bufs(8'h7F, 8'h01, 1'b0);
    run_frame(lat, nvalid, beam);
    tests_run++;
    if (beam !== 9'h080) begin
      tests_failed++;
      $display("FAIL signed_pos: got %h want 080", beam);
    end
  endtask

  task automatic test_commit_midframe;
    bit ok;
    logic [8:0] beam;
    bit seen;
    fill_bufs(8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) buf1[i] = 8'(i);
    shift_bits(1'b1, 4'b1011);
    ifc.cfg_commit = 1'b1;
    @(negedge clk);
    ifc.cfg_commit = 1'b0;
    tests_run++;
    if ({ifc.cfg_pending, ifc.rd_ch, ifc.rd_index} !== {1'b1, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL commit_pending: got %b want 1_1_0000", {ifc.cfg_pending, ifc.rd_ch, ifc.rd_index});
    end
    wait_strobe(ok);
    if (!ok) return;
    tests_run++;
    if (ifc.cfg_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL pending_until_strobe: got %b want 1", ifc.cfg_pending);
    end
    seen = 1'b0;
    beam = 9'h000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tests_run++;
        if (ifc.cfg_pending !== 1'b0) begin
          tests_failed++;
          $display("FAIL pending_cleared: got %b want 0", ifc.cfg_pending);
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({ifc.rd_ch, ifc.rd_index} !== {1'b1, 4'd11}) begin
          tests_failed++;
          $display("FAIL ch1_index: got %b want 1_1011", {ifc.rd_ch, ifc.rd_index});
        end
      end
      if (ifc.beam_valid && !seen) begin
        seen = 1'b1;
        beam = ifc.beam_out;
      end
    end
    tests_run++;
    if (beam !== 9'h01B) begin
      tests_failed++;
      $display("FAIL commit_beam: got %h want 01b", beam);
    end
    tests_run++;
    if ({ifc.rd_ch, ifc.rd_index} !== {1'b1, 4'd11}) begin
      tests_failed++;
      $display("FAIL rd_hold_idle: got %b want 1_1011", {ifc.rd_ch, ifc.rd_index});
    end
  endtask

  task automatic test_commit_on_strobe;
    bit ok;
    int lat, nvalid;
    logic [8:0] beam;
    for (int i = 0; i < 16; i++) begin
      buf0[i] = 8'h40 + 8'(i);
      buf1[i] = 8'(i);
    end
    shift_bits(1'b0, 4'b0101);
    wait_strobe(ok);
    if (!ok) return;
    ifc.cfg_commit = 1'b1;
    ifc.cfg_shift  = 1'b1;
    ifc.cfg_sel    = 1'b0;
    ifc.cfg_bit    = 1'b1;
    lat = -1;
    beam = 9'h000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        ifc.cfg_commit = 1'b0;
        ifc.cfg_shift  = 1'b0;
        tests_run++;
        if ({ifc.cfg_pending, ifc.rd_ch, ifc.rd_index} !== {1'b0, 1'b0, 4'd5}) begin
          tests_failed++;
          $display("FAIL strobe_commit_idx: got %b want 0_0_0101", {ifc.cfg_pending, ifc.rd_ch, ifc.rd_index});
        end
      end
      if (ifc.beam_valid && lat < 0) begin
        lat = i;
        beam = ifc.beam_out;
      end
    end
    tests_run++;
    if ({lat[3:0], beam} !== {4'd5, 9'h050}) begin
      tests_failed++;
      $display("FAIL strobe_commit_beam: got lat %0d beam %h want lat 5 beam 050", lat, beam);
    end
    ifc.cfg_commit = 1'b1;
    @(negedge clk);
    ifc.cfg_commit = 1'b0;
    run_frame(lat, nvalid, beam);
    tests_run++;
    if (beam !== 9'h056) begin
      tests_failed++;
      $display("FAIL post_shift_beam: got %h want 056", beam);
    end
  endtask

  task automatic test_reset_midsequence;
    bit ok;
    int first_valid, first_strobe;
    wait_strobe(ok);
    if (!ok) return;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ws_out, busy, ifc.beam_valid, ifc.cfg_pending, ifc.rd_ch, ifc.rd_index, ifc.beam_out} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got %h want 0", {ws_out, busy, ifc.beam_valid, ifc.cfg_pending, ifc.rd_ch, ifc.rd_index, ifc.beam_out});
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (ifc.beam_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_valid: got %b want 0", ifc.beam_valid);
      end
    end
    rst_n = 1'b1;
    first_valid = -1;
    first_strobe = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (frame_strobe && first_strobe < 0) first_strobe = i;
      if (ifc.beam_valid && first_valid < 0) begin
        first_valid = i;
        tests_run++;
        if (ifc.beam_out !== 9'h040) begin
          tests_failed++;
          $display("FAIL reset_beam: got %h want 040", ifc.beam_out);
        end
      end
    end
    // The release cycle holds count 0, so the strobe is 31 cycles later.
    tests_run++;
    if (first_strobe !== 31) begin
      tests_failed++;
      $display("FAIL reset_strobe_time: got %0d want 31", first_strobe);
    end
    tests_run++;
    if (first_valid !== 36) begin
      tests_failed++;
      $display("FAIL reset_beam_time: got %0d want 36", first_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    ena = 1'b0;
    ifc.cfg_sel = 1'b0;
    ifc.cfg_bit = 1'b0;
    ifc.cfg_shift = 1'b0;
    ifc.cfg_commit = 1'b0;
    fill_bufs(8'h00, 8'h00, 1'b0);
    test_reset();
    test_basic_sum();
    test_signed_sum();
    test_commit_midframe();
    test_commit_on_strobe();
    test_reset_midsequence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
